// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, FSM state type and buffer entry type for the fetch stage
// Purpose: common definitions imported by fetch_unit and fetch_ibuf.
// Ports: none (package).
package fetch_pkg;

    localparam int PC_W    = 36;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// rtl/fetch_ibuf.sv - synchronous FIFO of fetched instructions with flush
// Purpose: holds {instr, pc} entries between memory return and decode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, wdata       write an entry (ignored while flush is high)
//   pop               consume the head entry (ignored when empty)
//   flush             discard every entry; wins over push
//   rdata             head entry, zero when empty
//   count             entries held, 0..DEPTH
//   empty, full       occupancy flags
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ibuf_entry_t              wdata,
    output ibuf_entry_t              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    ibuf_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // The fetch FSM reserves a slot before issuing a request, so a push
    // into a full buffer without a simultaneous pop can never happen.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage owning the architectural PC
// Purpose: issues word-addressed fetches, buffers returned instructions with
// their PC, hands them to decode, and handles redirects with flush.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   redirect_valid, redirect_pc    load a new PC, flush buffer and in-flight fetch
//   imem_req, imem_addr, imem_gnt  request channel (one outstanding at most)
//   imem_rvalid, imem_rdata        response channel
//   if_valid, if_instr, if_pc      head instruction offered to decode
//   if_ready                       decode accepts the head this cycle
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              IBUF_DEPTH = 2
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_W-1:0]     if_pc,
    input  logic                if_ready
);

    localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  req_pc;
    logic             drop;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             slot_next;
    logic [CNT_W-1:0] count;
    ibuf_entry_t      wentry;
    ibuf_entry_t      head;

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // A response is kept only if no redirect has occurred since its request.
    assign push   = (state == WAIT) && imem_rvalid && !drop && !redirect_valid;
    assign pop    = if_valid && if_ready;
    assign wentry = '{instr: imem_rdata, pc: req_pc};

    // Occupancy after this edge stays below depth unless this push fills the
    // last free slot with nothing leaving.
    assign slot_next = !(push && !pop && (count == CNT_W'(IBUF_DEPTH - 1)));

    assign if_valid = !empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    fetch_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wentry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
            drop   <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
            case (state)
                // A granted request is already in flight: wait it out and drop it.
                // An ungranted one is withdrawn for a cycle via IDLE.
                REQ: begin
                    if (imem_gnt) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_gnt) begin
                        req_pc <= pc;
                        pc     <= pc + 1'b1;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= slot_next ? REQ : HOLD;
                    end
                end
                HOLD: begin
                    if (!full) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the architectural PC and sits directly upstream of decode.
- Issues word-addressed requests to instruction memory and buffers returned instructions with their PC.
- Presents them to decode through a valid/ready handshake.
- Accepts redirects from the branch/jump decoder output (pc_next) and flushes fetched-but-unconsumed instructions, including any in-flight response.

Parameters:
RESET_PC, 36'h0, PC loaded on reset
IBUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
redirect_valid  input  1  load redirect_pc, flush buffer and in-flight fetch
redirect_pc  input  36  target PC (branch/jump decoder pc_next)
imem_req  output  1  fetch request valid
imem_addr  output  36  word address of request
imem_gnt  input  1  request accepted this cycle (imem_req & imem_gnt)
imem_rvalid  input  1  response data valid
imem_rdata  input  32  instruction word
if_valid  output  1  instruction available to decode
if_instr  output  32  instruction at buffer head
if_pc  output  36  PC of if_instr
if_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=IDLE, buffer empty, drop=0.
  - Outputs: imem_req=0, if_valid=0, if_instr=0, if_pc=0, imem_addr=RESET_PC.
  - Reset mid-operation discards any outstanding response; a late imem_rvalid after reset is ignored while state!=WAIT.
- At most one outstanding memory request. A request is issued only when buffer count < IBUF_DEPTH, which reserves its slot.
- FSM:
  - IDLE: one cycle after reset -> REQ.
  - REQ: imem_req=1, imem_addr=pc. On gnt: req_pc<=pc, pc<=pc+1 (mod 2^36), -> WAIT.
  - WAIT: imem_req=0. On rvalid: if drop=0, push {imem_rdata, req_pc}; clear drop. Then -> REQ if the slot check passes next cycle, else -> HOLD.
  - HOLD: buffer full, imem_req=0; -> REQ once count < IBUF_DEPTH.
- Redirect (highest priority, any state):
  - pc<=redirect_pc; buffer flushed (if_valid=0 next cycle).
  - In WAIT without rvalid the same cycle: set drop=1, stay WAIT, and discard the eventual response.
  - In WAIT with rvalid the same cycle: discard that data, -> REQ.
  - In REQ with gnt the same cycle: request is in flight; -> WAIT with drop=1, and pc=redirect_pc (not incremented).
  - In REQ without gnt: imem_req drops for one cycle, then -> REQ with new pc. Memory must tolerate request withdrawal.
  - In IDLE/HOLD: -> REQ.
  - Earliest redirect_pc on imem_addr: cycle after redirect (no in-flight fetch).
- Latency: gnt at cycle N, rvalid at M -> if_valid at M+1 when buffer was empty. Redirect at N, gnt at N+1, rdata at N+2 -> if_valid at N+3.
- Decode handshake:
  - Transfer when if_valid & if_ready.
  - if_instr/if_pc stay stable while if_valid & !if_ready.
  - Push and pop in the same cycle are allowed; count unchanged.
  - With redirect_valid, a head transfer in that same cycle still completes; all remaining entries are flushed.
- FIFO pointers wrap modulo IBUF_DEPTH; count ranges 0..IBUF_DEPTH. Overflow is impossible by slot reservation (assertion required).
- PC increment is +1 (word addressed), matching the decoder's pc+immediate arithmetic; wraps 36'hF_FFFF_FFFF -> 0.

Decomposition:
- fetch_pkg: PC_W=36, INSTR_W=32, fetch_state_t enum {IDLE, REQ, WAIT, HOLD}, ibuf_entry_t struct {instr, pc}.
- Sub-module fetch_ibuf: synchronous FIFO of ibuf_entry_t with push, pop, flush, count, empty/full. Flush has priority over push, and pop is unaffected by flush.
- fetch_unit holds the FSM, pc, req_pc, and drop.

Test Plan:
- Reset with RESET_PC=36'h100, memory always gnt with 1-cycle rvalid, if_ready=1 -> imem_addr 100,101,102...; if_pc sequence 100,101,102; if_valid first high 4 cycles after rst deasserts.
- if_ready=0 for 10 cycles -> buffer fills to 2 entries and state HOLD, imem_req=0; if_instr/if_pc held constant. Release -> in-order delivery with no loss or duplication.
- Redirect to 36'h2000 while in WAIT (rvalid 3 cycles later) -> stale response dropped, next imem_addr=2000, first if_pc=2000, no stale if_valid.
- Redirect coincident with imem_gnt in REQ -> in-flight data dropped, next request addr = redirect target.
- PC=36'hF_FFFF_FFFF fetched -> next imem_addr=0.
- rst asserted while WAIT with response pending -> outputs at reset values next cycle; late rvalid ignored; fetch restarts at RESET_PC.
